// File: rtl/line_transfer_engine_pkg.sv
// Shared types for the line transfer engine: FSM states, hmem opcodes, width helper.
package line_transfer_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } line_xfer_state_e;

  typedef enum logic {
    HMEM_LOAD  = 1'b0,
    HMEM_STORE = 1'b1
  } hmem_op_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_if.sv
// Reset bundle shared by the cache blocks; reset is synchronous, active-high.
interface reset_if;
  logic reset;
  modport dut (input reset);
endinterface

// File: rtl/line_transfer_engine_counter.sv
// Shared beat counter: counts up or down, optionally wrapping at the terminal value.
module line_transfer_engine_counter #(
  parameter int unsigned       WIDTH          = 3,
  parameter logic [WIDTH-1:0]  MAX_COUNT      = '1,
  parameter bit                COUNT_UP       = 1'b1,
  parameter bit                CHECK_FOR_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             last_c
);

  localparam logic [WIDTH-1:0] START = COUNT_UP ? '0 : MAX_COUNT;
  localparam logic [WIDTH-1:0] STOP  = COUNT_UP ? MAX_COUNT : '0;

  // Terminal-count flag for the current value.
  assign last_c = CHECK_FOR_DONE ? (count == STOP) : 1'b0;

  // Count register; wraps back to START after the terminal value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= START;
    end else if (enable) begin
      if (CHECK_FOR_DONE && (count == STOP)) begin
        count <= START;
      end else if (COUNT_UP) begin
        count <= count + WIDTH'(1);
      end else begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/line_transfer_engine.sv
// Line transfer engine: moves whole cache lines between the data array and hmem in
// multi-word beats, with optional victim writeback ahead of the fill.
// Macro LINE_TRANSFER_CRIT_WORD_FIRST_EN: start the fill at the critical beat and wrap;
// without it the fill always starts at beat 0 (crit_valid still pulses on the critical beat).
module line_transfer_engine
  import line_transfer_engine_pkg::*;
#(
  parameter  int unsigned XLEN             = 32,
  parameter  int unsigned LINE_SIZE        = 32,
  parameter  int unsigned BEAT_WORDS       = 1,
  localparam int unsigned WORDS_PER_LINE   = LINE_SIZE / (XLEN / 8),
  localparam int unsigned OFS_SIZE         = $clog2(LINE_SIZE),
  localparam int unsigned WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE),
  localparam int unsigned NUM_BEATS        = WORDS_PER_LINE / BEAT_WORDS,
  localparam int unsigned BEAT_W           = XLEN * BEAT_WORDS,
  localparam int unsigned BEAT_SEL_W       = sel_width(NUM_BEATS)
) (
  input  logic                        clk,
  reset_if.dut                        rst_if,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_writeback,
  input  logic [XLEN-OFS_SIZE-1:0]    cmd_fill_block,
  input  logic [XLEN-OFS_SIZE-1:0]    cmd_victim_block,
  input  logic [WORD_SELECT_SIZE-1:0] cmd_crit_word,
  output logic                        busy,
  output logic                        done,
  output logic                        crit_valid,
  output logic [XLEN-1:0]             crit_data,
  output logic [BEAT_SEL_W-1:0]       arr_beat_select,
  output logic                        arr_we,
  output logic [BEAT_W-1:0]           arr_wdata,
  input  logic [BEAT_W-1:0]           arr_rdata,
  output logic                        hmem_req_valid,
  input  logic                        hmem_req_ready,
  output logic                        hmem_req_store,
  output logic [XLEN-1:0]             hmem_req_address,
  output logic [BEAT_W-1:0]           hmem_req_store_data,
  input  logic                        hmem_rsp_valid,
  input  logic [BEAT_W-1:0]           hmem_rsp_load_data
);

  localparam int unsigned BLOCK_W  = XLEN - OFS_SIZE;
  localparam int unsigned BEAT_OFS = $clog2(BEAT_W / 8);
  localparam int unsigned BW_LOG   = $clog2(BEAT_WORDS);
  localparam int unsigned WIB_W    = sel_width(BEAT_WORDS);

  line_xfer_state_e            state;
  logic [BLOCK_W-1:0]          fill_block_q;
  logic [BLOCK_W-1:0]          victim_block_q;
  logic [WORD_SELECT_SIZE-1:0] crit_word_q;
  logic [BEAT_SEL_W-1:0]       start_beat_q;

  logic [BEAT_SEL_W-1:0]       count;
  logic                        last_c;
  logic                        accept_c;
  logic                        rsp_accept_c;
  logic                        fill_rsp_c;
  logic [BEAT_SEL_W-1:0]       beat_idx;
  logic [BEAT_SEL_W-1:0]       crit_beat;
  logic [BEAT_SEL_W-1:0]       fill_start_cmd;
  logic [BEAT_SEL_W-1:0]       fill_start_q;
  logic [WIB_W-1:0]            wib;
  logic [XLEN-1:0]             crit_word_c;
  hmem_op_e                    req_op;
  logic [BLOCK_W-1:0]          req_block;
  logic [OFS_SIZE-1:0]         req_offset;

  // Command handshake and response qualification; responses during reset are dropped.
  assign accept_c     = (state == IDLE) && cmd_valid;
  assign rsp_accept_c = ((state == WB_WAIT) || (state == FILL_WAIT)) && hmem_rsp_valid
                        && !rst_if.reset;
  assign fill_rsp_c   = (state == FILL_WAIT) && hmem_rsp_valid && !rst_if.reset;

  // Beat of the requested word, and where the fill phase starts.
  assign crit_beat = BEAT_SEL_W'(crit_word_q >> BW_LOG);
`ifdef LINE_TRANSFER_CRIT_WORD_FIRST_EN
  assign fill_start_cmd = BEAT_SEL_W'(cmd_crit_word >> BW_LOG);
  assign fill_start_q   = crit_beat;
`else
  assign fill_start_cmd = '0;
  assign fill_start_q   = '0;
`endif

  // Completed-beat counter; wraps to 0 after the last beat of each phase.
  line_transfer_engine_counter #(
    .WIDTH          (BEAT_SEL_W),
    .MAX_COUNT      (BEAT_SEL_W'(NUM_BEATS - 1)),
    .COUNT_UP       (1'b1),
    .CHECK_FOR_DONE (1'b1)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (rst_if.reset),
    .clear  (accept_c),
    .enable (rsp_accept_c),
    .count  (count),
    .last_c (last_c)
  );

  // Wrap adder: NUM_BEATS is a power of two so the natural overflow is the modulo.
  assign beat_idx = start_beat_q + count;

  // Sequencer: command latch and state progression.
  always_ff @(posedge clk) begin
    if (rst_if.reset) begin
      state          <= IDLE;
      fill_block_q   <= '0;
      victim_block_q <= '0;
      crit_word_q    <= '0;
      start_beat_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            fill_block_q   <= cmd_fill_block;
            victim_block_q <= cmd_victim_block;
            crit_word_q    <= cmd_crit_word;
            if (cmd_writeback) begin
              start_beat_q <= '0;
              state        <= WB_REQ;
            end else begin
              start_beat_q <= fill_start_cmd;
              state        <= FILL_REQ;
            end
          end
        end
        WB_REQ: begin
          if (hmem_req_ready) state <= WB_WAIT;
        end
        WB_WAIT: begin
          if (hmem_rsp_valid) begin
            if (last_c) begin
              start_beat_q <= fill_start_q;
              state        <= FILL_REQ;
            end else begin
              state <= WB_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (hmem_req_ready) state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (hmem_rsp_valid) state <= last_c ? DONE : FILL_REQ;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decodes of the state register.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // hmem request: held stable from registered state, block and beat until accepted.
  assign hmem_req_valid      = (state == WB_REQ) || (state == FILL_REQ);
  assign req_op              = (state == WB_REQ) ? HMEM_STORE : HMEM_LOAD;
  assign hmem_req_store      = hmem_req_valid && (req_op == HMEM_STORE);
  assign req_block           = (state == WB_REQ) ? victim_block_q : fill_block_q;
  assign req_offset          = OFS_SIZE'(beat_idx) << BEAT_OFS;
  assign hmem_req_address    = hmem_req_valid ? {req_block, req_offset} : '0;
  assign hmem_req_store_data = arr_rdata;

  // Data array port: read during writeback, written straight from fill responses.
  assign arr_beat_select = beat_idx;
  assign arr_we          = fill_rsp_c;
  assign arr_wdata       = fill_rsp_c ? hmem_rsp_load_data : '0;

  // Word of the critical beat that the requester asked for.
  assign wib = (BEAT_WORDS > 1) ? WIB_W'(crit_word_q) : '0;

  // Select the critical word out of the response beat.
  always_comb begin
    crit_word_c = '0;
    for (int unsigned i = 0; i < BEAT_WORDS; i++) begin
      if (wib == WIB_W'(i)) crit_word_c = hmem_rsp_load_data[i*XLEN +: XLEN];
    end
  end

  // Early restart: same-cycle forward of the critical word as its beat lands.
  assign crit_valid = fill_rsp_c && (beat_idx == crit_beat);
  assign crit_data  = crit_valid ? crit_word_c : '0;

endmodule

// File: tb/tb_line_transfer_engine.sv
// Directed bench for line_transfer_engine with 32-byte lines and 2-word beats (4 beats).
module tb_line_transfer_engine;

`ifdef LINE_TRANSFER_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  reset_if rst_if();

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_writeback;
  logic [26:0] cmd_fill_block;
  logic [26:0] cmd_victim_block;
  logic [2:0]  cmd_crit_word;
  logic        busy;
  logic        done;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic [1:0]  arr_beat_select;
  logic        arr_we;
  logic [63:0] arr_wdata;
  logic [63:0] arr_rdata;
  logic        hmem_req_valid;
  logic        hmem_req_ready;
  logic        hmem_req_store;
  logic [31:0] hmem_req_address;
  logic [63:0] hmem_req_store_data;
  logic        hmem_rsp_valid;
  logic [63:0] hmem_rsp_load_data;

  line_transfer_engine #(
    .XLEN       (32),
    .LINE_SIZE  (32),
    .BEAT_WORDS (2)
  ) dut (
    .clk                 (clk),
    .rst_if              (rst_if),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_writeback       (cmd_writeback),
    .cmd_fill_block      (cmd_fill_block),
    .cmd_victim_block    (cmd_victim_block),
    .cmd_crit_word       (cmd_crit_word),
    .busy                (busy),
    .done                (done),
    .crit_valid          (crit_valid),
    .crit_data           (crit_data),
    .arr_beat_select     (arr_beat_select),
    .arr_we              (arr_we),
    .arr_wdata           (arr_wdata),
    .arr_rdata           (arr_rdata),
    .hmem_req_valid      (hmem_req_valid),
    .hmem_req_ready      (hmem_req_ready),
    .hmem_req_store      (hmem_req_store),
    .hmem_req_address    (hmem_req_address),
    .hmem_req_store_data (hmem_req_store_data),
    .hmem_rsp_valid      (hmem_rsp_valid),
    .hmem_rsp_load_data  (hmem_rsp_load_data)
  );

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  int t0     = 0;

  // Victim line contents held in the array model.
  logic [63:0] arr_mem [4];
  assign arr_rdata = arr_mem[arr_beat_select];

  // hmem returns a recognisable pattern derived from the beat address.
  function automatic logic [63:0] load_pat(input logic [31:0] a);
    return {32'hC000_0000 | (a + 32'd4), 32'hA000_0000 | a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Responder: answers each accepted request one cycle later when enabled.
  bit          rsp_en = 1'b1;
  bit          hs_seen = 1'b0;
  logic [31:0] hs_addr = '0;
  always @(negedge clk) begin
    hs_seen = hmem_req_valid && hmem_req_ready;
    hs_addr = hmem_req_address;
  end
  always @(posedge clk) begin
    #1;
    if (rsp_en) begin
      hmem_rsp_valid     = hs_seen;
      hmem_rsp_load_data = hs_seen ? load_pat(hs_addr) : '0;
    end
  end

  // Transaction logs.
  logic [31:0] req_addr_q [$];
  logic        req_store_q [$];
  logic [63:0] req_data_q [$];
  logic [1:0]  wr_sel_q [$];
  logic [63:0] wr_data_q [$];
  int          crit_cyc_q [$];
  logic [31:0] crit_data_q [$];
  int          done_cyc_q [$];

  always @(negedge clk) begin
    if (hmem_req_valid && hmem_req_ready) begin
      req_addr_q.push_back(hmem_req_address);
      req_store_q.push_back(hmem_req_store);
      req_data_q.push_back(hmem_req_store_data);
    end
    if (arr_we) begin
      wr_sel_q.push_back(arr_beat_select);
      wr_data_q.push_back(arr_wdata);
    end
    if (crit_valid) begin
      crit_cyc_q.push_back(ncyc - t0);
      crit_data_q.push_back(crit_data);
    end
    if (done) done_cyc_q.push_back(ncyc - t0);
  end

  task automatic clear_logs();
    req_addr_q.delete();
    req_store_q.delete();
    req_data_q.delete();
    wr_sel_q.delete();
    wr_data_q.delete();
    crit_cyc_q.delete();
    crit_data_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Offer a command; returns just after the accepting edge (relative cycle 1).
  task automatic issue(input bit wb, input logic [26:0] fb, input logic [26:0] vb,
                       input logic [2:0] cw, input bit hold);
    drive_edge();
    cmd_valid        = 1'b1;
    cmd_writeback    = wb;
    cmd_fill_block   = fb;
    cmd_victim_block = vb;
    cmd_crit_word    = cw;
    tick();
    check_eq("accept_ready", cmd_ready, 1);
    t0 = ncyc;
    clear_logs();
    drive_edge();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_rel);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = done;
    end
    check_eq("done_seen", seen, 1);
    check_eq("done_cycle", ncyc - t0, exp_rel);
    tick();
    check_eq("ready_after_done", cmd_ready, 1);
    check_eq("done_one_cycle", done, 0);
    check_eq("done_count", done_cyc_q.size(), 1);
  endtask

  task automatic check_fill(input logic [31:0] base, input int start, input int ofs);
    check_eq("fill_req_count", req_addr_q.size(), ofs + 4);
    check_eq("fill_wr_count", wr_sel_q.size(), 4);
    if (req_addr_q.size() >= ofs + 4 && wr_sel_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        int          beat;
        logic [31:0] a;
        beat = (start + i) % 4;
        a    = base + 32'(beat * 8);
        check_eq("fill_addr", req_addr_q[ofs+i], a);
        check_eq("fill_is_load", req_store_q[ofs+i], 0);
        check_eq("fill_beat_sel", wr_sel_q[i], beat);
        check_eq("fill_wdata", wr_data_q[i], load_pat(a));
      end
    end
  endtask

  task automatic check_wb(input logic [31:0] base);
    if (req_addr_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("wb_addr", req_addr_q[i], base + 32'(i * 8));
        check_eq("wb_is_store", req_store_q[i], 1);
        check_eq("wb_data", req_data_q[i], arr_mem[i]);
      end
    end else begin
      check_eq("wb_req_count", req_addr_q.size(), 4);
    end
  endtask

  task automatic check_crit(input int exp_rel, input logic [31:0] exp_data);
    check_eq("crit_count", crit_cyc_q.size(), 1);
    if (crit_cyc_q.size() >= 1) begin
      check_eq("crit_cycle", crit_cyc_q[0], exp_rel);
      check_eq("crit_data", crit_data_q[0], exp_data);
    end
  endtask

  initial begin
    arr_mem[0] = 64'h1111_0000_AAAA_0000;
    arr_mem[1] = 64'h2222_0001_BBBB_0001;
    arr_mem[2] = 64'h3333_0002_CCCC_0002;
    arr_mem[3] = 64'h4444_0003_DDDD_0003;
    rst_if.reset       = 1'b1;
    cmd_valid          = 1'b0;
    cmd_writeback      = 1'b0;
    cmd_fill_block     = '0;
    cmd_victim_block   = '0;
    cmd_crit_word      = '0;
    hmem_req_ready     = 1'b1;
    hmem_rsp_valid     = 1'b0;
    hmem_rsp_load_data = '0;

    // Reset values.
    repeat (3) tick();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_crit_valid", crit_valid, 0);
    check_eq("rst_crit_data", crit_data, 0);
    check_eq("rst_arr_we", arr_we, 0);
    check_eq("rst_arr_wdata", arr_wdata, 0);
    check_eq("rst_req_valid", hmem_req_valid, 0);
    check_eq("rst_req_store", hmem_req_store, 0);
    check_eq("rst_req_addr", hmem_req_address, 0);
    drive_edge();
    rst_if.reset = 1'b0;
    tick();

    // Fill-only, block 0x40, critical word 5 (beat 2, upper word).
    issue(1'b0, 27'h40, 27'h0, 3'd5, 1'b0);
    wait_done(9);
    check_fill(32'h800, CWF ? 2 : 0, 0);
    check_crit(CWF ? 2 : 6, 32'hC000_0814);

    // Writeback victim 0x20, then fill 0x40 with critical word 5.
    issue(1'b1, 27'h40, 27'h20, 3'd5, 1'b0);
    wait_done(17);
    check_eq("wbf_req_count", req_addr_q.size(), 8);
    check_wb(32'h400);
    check_fill(32'h800, CWF ? 2 : 0, 4);
    check_crit(CWF ? 10 : 14, 32'hC000_0814);

    // Request stalled by hmem_req_ready low for three cycles.
    hmem_req_ready = 1'b0;
    issue(1'b1, 27'h41, 27'h20, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", hmem_req_valid, 1);
      check_eq("stall_store", hmem_req_store, 1);
      check_eq("stall_addr", hmem_req_address, 32'h400);
      check_eq("stall_data", hmem_req_store_data, arr_mem[0]);
    end
    drive_edge();
    hmem_req_ready = 1'b1;
    wait_done(20);
    check_eq("stall_req_count", req_addr_q.size(), 8);
    check_wb(32'h400);
    check_fill(32'h820, 0, 4);

    // Reset while waiting for the third fill beat; responses around it are dropped.
    issue(1'b0, 27'h40, 27'h0, 3'd0, 1'b0);
    repeat (5) tick();
    check_eq("mid_req_count", req_addr_q.size(), 3);
    rsp_en = 1'b0;
    drive_edge();
    rst_if.reset       = 1'b1;
    hmem_rsp_valid     = 1'b1;
    hmem_rsp_load_data = load_pat(32'h810);
    tick();
    check_eq("mid_busy_in_wait", busy, 1);
    check_eq("mid_rst_arr_we", arr_we, 0);
    check_eq("mid_rst_crit", crit_valid, 0);
    drive_edge();
    rst_if.reset = 1'b0;
    tick();
    check_eq("mid_idle_ready", cmd_ready, 1);
    check_eq("mid_idle_busy", busy, 0);
    check_eq("mid_late_arr_we", arr_we, 0);
    check_eq("mid_req_valid", hmem_req_valid, 0);
    check_eq("mid_req_addr", hmem_req_address, 0);
    drive_edge();
    hmem_rsp_valid     = 1'b0;
    hmem_rsp_load_data = '0;
    rsp_en             = 1'b1;
    tick();
    check_eq("mid_wr_count", wr_sel_q.size(), 2);
    check_eq("mid_no_done", done_cyc_q.size(), 0);

    // cmd_valid held through a command with changed fields: ignored until after done.
    issue(1'b0, 27'h40, 27'h0, 3'd0, 1'b1);
    cmd_fill_block   = 27'h7F;
    cmd_victim_block = 27'h11;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        tick();
        seen = done;
      end
      check_eq("hold_done_seen", seen, 1);
      check_eq("hold_done_cycle", ncyc - t0, 9);
      check_eq("hold_ready_in_done", cmd_ready, 0);
    end
    check_fill(32'h800, 0, 0);
    tick();
    check_eq("hold_ready_after", cmd_ready, 1);
    t0 = ncyc;
    drive_edge();
    cmd_valid = 1'b0;
    clear_logs();
    tick();
    check_eq("hold_second_valid", hmem_req_valid, 1);
    check_eq("hold_second_addr", hmem_req_address, 32'hFE0);
    wait_done(9);
    check_fill(32'hFE0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
